// File: rtl/wb_master_pkg.sv
// Shared types for the fabric-side Wishbone initiator: FSM state encoding,
// default bus widths and the command record.
package wb_master_pkg;

  localparam int unsigned ADR_W_DEF = 17;
  localparam int unsigned DAT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                   we;
    logic [ADR_W_DEF-1:0]   adr;
    logic [DAT_W_DEF/8-1:0] be;
    logic [DAT_W_DEF-1:0]   dat;
  } wb_cmd_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// 16-bit bus-cycle counter with synchronous clear/enable; expired_o flags the
// enabled cycle in which the count sits at LIMIT-1.
module wb_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired_o = en && (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/wb_master_seq.sv
// Single-transaction Wishbone initiator: takes one command on a valid/ready
// port, runs one bus cycle with timeout, and returns read data / error.
module wb_master_seq
  import wb_master_pkg::*;
#(
  parameter int unsigned ADR_W       = ADR_W_DEF,
  parameter int unsigned DAT_W       = DAT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          RSP_ON_WR   = 1'b1
) (
  input  logic               WB_CLK,
  input  logic               WB_RSTn,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [ADR_W-1:0]   cmd_adr_i,
  input  logic [DAT_W/8-1:0] cmd_be_i,
  input  logic [DAT_W-1:0]   cmd_dat_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DAT_W-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               err_sticky_o,
  input  logic               err_clr_i,
  output logic               busy_o,
  output logic [ADR_W-1:0]   WBs_ADR,
  output logic               WBs_CYC,
  output logic               WBs_STB,
  output logic               WBs_WE,
  output logic               WBs_RD,
  output logic [DAT_W/8-1:0] WBs_BYTE_STB,
  output logic [DAT_W-1:0]   WBs_WR_DAT,
  input  logic [DAT_W-1:0]   WBs_RD_DAT,
  input  logic               WBs_ACK
);

  localparam int unsigned BE_W = DAT_W / 8;

  typedef struct packed {
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [BE_W-1:0]   be;
    logic [DAT_W-1:0]  dat;
  } cmd_t;

  wb_state_e        state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic             cyc_q, cyc_d;
  logic             rd_q;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic             sticky_q, sticky_set;
  logic             accept, cnt_en, expired, posted_wr;

  assign accept    = (state_q == ST_IDLE) && cmd_valid_i;
  assign cnt_en    = (state_q == ST_BUS) && !WBs_ACK;
  assign posted_wr = cmd_q.we && !RSP_ON_WR;

  wb_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk       (WB_CLK),
    .rst_n     (WB_RSTn),
    .clr       (accept),
    .en        (cnt_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cyc_d      = cyc_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_err_d  = rsp_err_q;
    sticky_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d.we  = cmd_we_i;
          cmd_d.adr = cmd_adr_i;
          cmd_d.be  = cmd_be_i;
          cmd_d.dat = cmd_dat_i;
          cyc_d     = 1'b1;
          state_d   = ST_BUS;
        end
      end
      ST_BUS: begin
        // ACK is tested before expiry so a same-edge ACK completes cleanly.
        if (WBs_ACK) begin
          cyc_d     = 1'b0;
          rsp_err_d = 1'b0;
          rsp_dat_d = cmd_q.we ? '0 : WBs_RD_DAT;
          state_d   = posted_wr ? ST_IDLE : ST_RESP;
        end else if (expired) begin
          cyc_d      = 1'b0;
          rsp_err_d  = 1'b1;
          rsp_dat_d  = '0;
          sticky_set = posted_wr;
          state_d    = posted_wr ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      cyc_q     <= 1'b0;
      rd_q      <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cyc_q     <= cyc_d;
      rd_q      <= cyc_d & ~cmd_d.we;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      if (sticky_set)     sticky_q <= 1'b1;
      else if (err_clr_i) sticky_q <= 1'b0;
    end
  end

  assign cmd_ready_o  = (state_q == ST_IDLE) && WB_RSTn;
  assign busy_o       = (state_q != ST_IDLE);
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_err_o    = rsp_err_q;
  assign err_sticky_o = sticky_q;

  assign WBs_ADR      = cmd_q.adr;
  assign WBs_CYC      = cyc_q;
  assign WBs_STB      = cyc_q;
  assign WBs_WE       = cmd_q.we;
  assign WBs_RD       = rd_q;
  assign WBs_BYTE_STB = cmd_q.be;
  assign WBs_WR_DAT   = cmd_q.dat;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench: instance a (timeout 8, write responses), instance b
// (timeout 1, posted writes); expectations are hand-computed constants.
module tb_wb_master_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance a
  logic        a_cmd_valid = 0, a_cmd_ready, a_cmd_we = 0;
  logic [16:0] a_cmd_adr = '0;
  logic [3:0]  a_cmd_be = '0;
  logic [31:0] a_cmd_dat = '0;
  logic        a_rsp_valid, a_rsp_ready = 0, a_rsp_err, a_sticky, a_err_clr = 0, a_busy;
  logic [31:0] a_rsp_dat;
  logic [16:0] a_adr;
  logic        a_cyc, a_stb, a_we, a_rd, a_ack = 0;
  logic [3:0]  a_bstb;
  logic [31:0] a_wdat, a_rdat = '0;

  // Instance b
  logic        b_cmd_valid = 0, b_cmd_ready, b_cmd_we = 0;
  logic [16:0] b_cmd_adr = '0;
  logic [3:0]  b_cmd_be = '0;
  logic [31:0] b_cmd_dat = '0;
  logic        b_rsp_valid, b_rsp_ready = 0, b_rsp_err, b_sticky, b_err_clr = 0, b_busy;
  logic [31:0] b_rsp_dat;
  logic [16:0] b_adr;
  logic        b_cyc, b_stb, b_we, b_rd, b_ack = 0;
  logic [3:0]  b_bstb;
  logic [31:0] b_wdat, b_rdat = '0;

  wb_master_seq #(.ADR_W(17), .DAT_W(32), .TIMEOUT_CYC(8), .RSP_ON_WR(1'b1)) dut_a (
    .WB_CLK(clk), .WB_RSTn(rst_n),
    .cmd_valid_i(a_cmd_valid), .cmd_ready_o(a_cmd_ready), .cmd_we_i(a_cmd_we),
    .cmd_adr_i(a_cmd_adr), .cmd_be_i(a_cmd_be), .cmd_dat_i(a_cmd_dat),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_dat_o(a_rsp_dat),
    .rsp_err_o(a_rsp_err), .err_sticky_o(a_sticky), .err_clr_i(a_err_clr), .busy_o(a_busy),
    .WBs_ADR(a_adr), .WBs_CYC(a_cyc), .WBs_STB(a_stb), .WBs_WE(a_we), .WBs_RD(a_rd),
    .WBs_BYTE_STB(a_bstb), .WBs_WR_DAT(a_wdat), .WBs_RD_DAT(a_rdat), .WBs_ACK(a_ack)
  );

  wb_master_seq #(.ADR_W(17), .DAT_W(32), .TIMEOUT_CYC(1), .RSP_ON_WR(1'b0)) dut_b (
    .WB_CLK(clk), .WB_RSTn(rst_n),
    .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_we_i(b_cmd_we),
    .cmd_adr_i(b_cmd_adr), .cmd_be_i(b_cmd_be), .cmd_dat_i(b_cmd_dat),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_dat_o(b_rsp_dat),
    .rsp_err_o(b_rsp_err), .err_sticky_o(b_sticky), .err_clr_i(b_err_clr), .busy_o(b_busy),
    .WBs_ADR(b_adr), .WBs_CYC(b_cyc), .WBs_STB(b_stb), .WBs_WE(b_we), .WBs_RD(b_rd),
    .WBs_BYTE_STB(b_bstb), .WBs_WR_DAT(b_wdat), .WBs_RD_DAT(b_rdat), .WBs_ACK(b_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(a_cmd_ready), 32'd0);
    chk("rst_cyc", 32'(a_cyc), 32'd0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(a_cmd_ready), 32'd1);
    chk("rel_cmd_ready_b", 32'(b_cmd_ready), 32'd1);
    tick();

    // Write, ACK in first bus cycle
    a_cmd_valid = 1; a_cmd_we = 1; a_cmd_adr = 17'h00004; a_cmd_be = 4'hF; a_cmd_dat = 32'hA5A5_1234;
    tick();
    a_cmd_valid = 0;
    chk("wr_cyc", 32'(a_cyc), 32'd1);
    chk("wr_stb", 32'(a_stb), 32'd1);
    chk("wr_we", 32'(a_we), 32'd1);
    chk("wr_rd", 32'(a_rd), 32'd0);
    chk("wr_adr", 32'(a_adr), 32'h00004);
    chk("wr_be", 32'(a_bstb), 32'hF);
    chk("wr_dat", a_wdat, 32'hA5A5_1234);
    chk("wr_busy", 32'(a_busy), 32'd1);
    chk("wr_cmd_ready", 32'(a_cmd_ready), 32'd0);
    chk("wr_rsp_early", 32'(a_rsp_valid), 32'd0);
    a_ack = 1; a_rdat = 32'h1234_5678;
    tick();
    a_ack = 0; a_rdat = '0;
    chk("wr_cyc_drop", 32'(a_cyc), 32'd0);
    chk("wr_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(a_rsp_err), 32'd0);
    chk("wr_rsp_dat", a_rsp_dat, 32'd0);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    chk("wr_rsp_done", 32'(a_rsp_valid), 32'd0);
    chk("wr_idle_ready", 32'(a_cmd_ready), 32'd1);

    // Read with 3 wait states
    a_cmd_valid = 1; a_cmd_we = 0; a_cmd_adr = 17'h1FFFC; a_cmd_be = 4'hF; a_cmd_dat = 32'h0;
    tick();
    a_cmd_valid = 0;
    chk("rd_rd", 32'(a_rd), 32'd1);
    chk("rd_we", 32'(a_we), 32'd0);
    chk("rd_adr", 32'(a_adr), 32'h1FFFC);
    for (int i = 0; i < 3; i++) begin
      chk("rd_cyc_wait", 32'(a_cyc), 32'd1);
      tick();
    end
    chk("rd_cyc_4th", 32'(a_cyc), 32'd1);
    a_ack = 1; a_rdat = 32'hDEAD_BEEF;
    tick();
    a_ack = 0; a_rdat = '0;
    chk("rd_cyc_drop", 32'(a_cyc), 32'd0);
    chk("rd_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("rd_rsp_dat", a_rsp_dat, 32'hDEAD_BEEF);
    chk("rd_rsp_err", 32'(a_rsp_err), 32'd0);

    // Back-pressure with a second command waiting
    a_cmd_valid = 1; a_cmd_we = 1; a_cmd_adr = 17'h00008; a_cmd_dat = 32'h0000_0055;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp_rsp_dat", a_rsp_dat, 32'hDEAD_BEEF);
      chk("bp_cmd_ready", 32'(a_cmd_ready), 32'd0);
      chk("bp_cyc", 32'(a_cyc), 32'd0);
    end
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    chk("bp_consumed", 32'(a_rsp_valid), 32'd0);
    chk("bp_idle_gap_cyc", 32'(a_cyc), 32'd0);
    chk("bp_ready_again", 32'(a_cmd_ready), 32'd1);
    tick();
    a_cmd_valid = 0;
    chk("bp_second_cyc", 32'(a_cyc), 32'd1);
    chk("bp_second_adr", 32'(a_adr), 32'h00008);
    a_ack = 1;
    tick();
    a_ack = 0;
    chk("bp_second_rsp", 32'(a_rsp_valid), 32'd1);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;

    // Read timeout (8 cycles), late ACK ignored
    a_cmd_valid = 1; a_cmd_we = 0; a_cmd_adr = 17'h00010;
    tick();
    a_cmd_valid = 0; a_rdat = 32'hBAD0_BAD0;
    for (int i = 0; i < 8; i++) begin
      chk("to_cyc_hold", 32'(a_cyc), 32'd1);
      tick();
    end
    chk("to_cyc_drop", 32'(a_cyc), 32'd0);
    chk("to_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(a_rsp_err), 32'd1);
    chk("to_rsp_dat", a_rsp_dat, 32'd0);
    tick();
    a_ack = 1; a_rdat = 32'hFFFF_FFFF;
    tick();
    a_ack = 0; a_rdat = '0;
    chk("late_ack_err", 32'(a_rsp_err), 32'd1);
    chk("late_ack_dat", a_rsp_dat, 32'd0);
    chk("late_ack_valid", 32'(a_rsp_valid), 32'd1);
    chk("late_ack_cyc", 32'(a_cyc), 32'd0);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    chk("to_consumed", 32'(a_rsp_valid), 32'd0);

    // ACK on the same edge as the timeout
    a_cmd_valid = 1; a_cmd_we = 0; a_cmd_adr = 17'h00020;
    tick();
    a_cmd_valid = 0;
    repeat (7) tick();
    chk("race_cyc", 32'(a_cyc), 32'd1);
    a_ack = 1; a_rdat = 32'h1357_9BDF;
    tick();
    a_ack = 0; a_rdat = '0;
    chk("race_valid", 32'(a_rsp_valid), 32'd1);
    chk("race_err", 32'(a_rsp_err), 32'd0);
    chk("race_dat", a_rsp_dat, 32'h1357_9BDF);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;

    // Posted write timeout on b (TIMEOUT_CYC=1)
    b_cmd_valid = 1; b_cmd_we = 1; b_cmd_adr = 17'h00100; b_cmd_be = 4'h3; b_cmd_dat = 32'hCAFE_0001;
    tick();
    b_cmd_valid = 0;
    chk("pw_cyc", 32'(b_cyc), 32'd1);
    tick();
    chk("pw_cyc_drop", 32'(b_cyc), 32'd0);
    chk("pw_no_rsp", 32'(b_rsp_valid), 32'd0);
    chk("pw_sticky", 32'(b_sticky), 32'd1);
    chk("pw_ready", 32'(b_cmd_ready), 32'd1);
    tick();
    chk("pw_sticky_hold", 32'(b_sticky), 32'd1);
    b_err_clr = 1;
    tick();
    b_err_clr = 0;
    chk("pw_cleared", 32'(b_sticky), 32'd0);
    b_cmd_valid = 1;
    #1;
    chk("pw_next_ready", 32'(b_cmd_ready), 32'd1);
    tick();
    b_cmd_valid = 0;
    chk("pw_next_cyc", 32'(b_cyc), 32'd1);
    b_err_clr = 1;
    tick();
    b_err_clr = 0;
    chk("pw_set_wins", 32'(b_sticky), 32'd1);
    b_err_clr = 1;
    tick();
    b_err_clr = 0;
    b_cmd_valid = 1;
    tick();
    b_cmd_valid = 0;
    b_ack = 1;
    tick();
    b_ack = 0;
    chk("pw_ack_no_rsp", 32'(b_rsp_valid), 32'd0);
    chk("pw_ack_sticky", 32'(b_sticky), 32'd0);
    chk("pw_ack_ready", 32'(b_cmd_ready), 32'd1);

    // Asynchronous reset mid-BUS
    a_cmd_valid = 1; a_cmd_we = 1; a_cmd_adr = 17'h00044; a_cmd_be = 4'hC; a_cmd_dat = 32'h7777_8888;
    tick();
    a_cmd_valid = 0;
    chk("ar_cyc_before", 32'(a_cyc), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_cyc", 32'(a_cyc), 32'd0);
    chk("ar_stb", 32'(a_stb), 32'd0);
    chk("ar_we", 32'(a_we), 32'd0);
    chk("ar_rd", 32'(a_rd), 32'd0);
    chk("ar_adr", 32'(a_adr), 32'd0);
    chk("ar_be", 32'(a_bstb), 32'd0);
    chk("ar_wdat", a_wdat, 32'd0);
    chk("ar_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("ar_busy", 32'(a_busy), 32'd0);
    chk("ar_cmd_ready", 32'(a_cmd_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("ar_rel_ready", 32'(a_cmd_ready), 32'd1);
    tick();
    chk("ar_no_rsp", 32'(a_rsp_valid), 32'd0);
    chk("ar_no_cyc", 32'(a_cyc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
